// File: rtl/ahb_memory_subordinate_pkg.sv
// Purpose: shared AHB encodings and burst helpers for the memory subordinate
// and its burst tracker.
// Ports: none (package).
package ahb_memory_subordinate_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } ahbTransferEnum;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } ahbBurstEnum;

  typedef enum logic [2:0] {
    HSIZE_BYTE     = 3'd0,
    HSIZE_HALFWORD = 3'd1,
    HSIZE_WORD     = 3'd2,
    HSIZE_DWORD    = 3'd3,
    HSIZE_LINE4    = 3'd4,
    HSIZE_LINE8    = 3'd5,
    HSIZE_LINE16   = 3'd6,
    HSIZE_LINE32   = 3'd7
  } ahbHsizeEnum;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } ahbRespEnum;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } sub_state_e;

  localparam int unsigned KB_BITS = 10;

  // Beats in a burst; SINGLE counts as one, INCR is unlimited (0).
  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    case (burst)
      HBURST_SINGLE:               burst_beats = 5'd1;
      HBURST_WRAP4, HBURST_INCR4:  burst_beats = 5'd4;
      HBURST_WRAP8, HBURST_INCR8:  burst_beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
      default:                     burst_beats = 5'd0;
    endcase
  endfunction

  function automatic logic burst_is_wrap(input logic [2:0] burst);
    burst_is_wrap = (burst == HBURST_WRAP4) || (burst == HBURST_WRAP8) ||
                    (burst == HBURST_WRAP16);
  endfunction

endpackage

// File: rtl/ahb_memory_subordinate_burst_tracker.sv
// Purpose: tracks the current burst so SEQ beats can be checked.
// Ports:
//   hclk, hreset        clock, async active-high reset
//   load                accepted, error-free NONSEQ
//   advance             accepted, error-free SEQ
//   clear               accepted transfer that failed a check
//   haddr/hburst/hsize  address phase of the transfer being accepted
//   exp_addr            address the next SEQ must carry
//   seq_ok              a further SEQ beat is permitted
//   cross_1k            next incrementing beat would start a new 1KB page
module ahb_burst_tracker
  import ahb_memory_subordinate_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  load,
  input  logic                  advance,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [2:0]            hburst,
  input  logic [2:0]            hsize,
  output logic [ADDR_WIDTH-1:0] exp_addr,
  output logic                  seq_ok,
  output logic                  cross_1k
);

  logic       active;
  logic       unlimited;
  logic [2:0] burst_r;
  logic [2:0] size_r;
  logic [4:0] beats_left;

  function automatic logic [ADDR_WIDTH-1:0] next_of(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [2:0] b,
                                                     input logic [2:0] s);
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] span;
    inc  = a + (ADDR_WIDTH'(1) << s);
    span = ADDR_WIDTH'(burst_beats(b)) << s;
    if (burst_is_wrap(b)) next_of = (a & ~(span - 1'b1)) | (inc & (span - 1'b1));
    else                  next_of = inc;
  endfunction

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      active     <= 1'b0;
      unlimited  <= 1'b0;
      burst_r    <= '0;
      size_r     <= '0;
      beats_left <= '0;
      exp_addr   <= '0;
    end else if (clear) begin
      active     <= 1'b0;
    end else if (load) begin
      active     <= 1'b1;
      unlimited  <= (hburst == HBURST_INCR);
      burst_r    <= hburst;
      size_r     <= hsize;
      beats_left <= burst_beats(hburst) - 5'd1;
      exp_addr   <= next_of(haddr, hburst, hsize);
    end else if (advance) begin
      if (beats_left != '0) beats_left <= beats_left - 5'd1;
      exp_addr <= next_of(haddr, burst_r, size_r);
    end
  end

  assign seq_ok   = active && (unlimited || beats_left != '0);
  // Beats are aligned and ascending, so a next address at a page start means
  // the beat would leave the page the burst is in.
  assign cross_1k = active && !burst_is_wrap(burst_r) && (exp_addr[KB_BITS-1:0] == '0);

endmodule

// File: rtl/ahb_memory_subordinate.sv
// Purpose: AHB subordinate backed by a byte-addressable memory with
// programmable wait states and protocol checking (range, size, alignment,
// SEQ address/beat count, 1KB boundary), two-cycle ERROR response.
// Ports:
//   hclk, hreset                     clock, async active-high reset
//   hselx, haddr, htrans, hburst,
//   hsize, hwrite                    address phase
//   hwdata, hwstrb                   data-phase write data and strobes
//   hready                           combined bus ready
//   wait_states                      wait cycles for the accepted transfer
//   hreadyout, hresp, hrdata         data-phase response
//
//   state   | meaning
//   ST_IDLE | no transfer pending, zero-wait OKAY
//   ST_DATA | data phase, wcnt wait cycles left
//   ST_ERR1 | first ERROR cycle, hreadyout low
//   ST_ERR2 | second ERROR cycle, hreadyout high
module ahb_memory_subordinate
  import ahb_memory_subordinate_pkg::*;
#(
  parameter int                  ADDR_WIDTH    = 32,
  parameter int                  DATA_WIDTH    = 32,
  parameter int                  MEM_ADDR_BITS = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                  WS_WIDTH      = 4
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hselx,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic [2:0]              hburst,
  input  logic [2:0]              hsize,
  input  logic                    hwrite,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  input  logic [WS_WIDTH-1:0]     wait_states,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [DATA_WIDTH-1:0]   hrdata
);

  localparam int NB        = DATA_WIDTH / 8;
  localparam int LB        = $clog2(NB);
  localparam int MEM_BYTES = 2 ** MEM_ADDR_BITS;

  logic [7:0] mem [MEM_BYTES];

  sub_state_e                 state, state_next;
  logic [MEM_ADDR_BITS-1:0]   off_r;
  logic [2:0]                 size_r;
  logic                       write_r;
  logic [WS_WIDTH-1:0]        wcnt;

  logic                       done, accept, xfer, err;
  logic [ADDR_WIDTH-1:0]      offset;
  logic                       range_err, size_err, align_err, seq_err;
  logic [ADDR_WIDTH-1:0]      exp_addr;
  logic                       seq_ok, cross_1k;
  logic [NB-1:0]              lanes;
  logic [MEM_ADDR_BITS-LB-1:0] word_idx;

  assign done   = (state == ST_IDLE) || (state == ST_ERR2) ||
                  (state == ST_DATA && wcnt == '0);
  assign accept = hselx && hready && done;
  assign xfer   = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);

  // An address below BASE_ADDR wraps to a huge offset, so one compare covers
  // both ends of the window.
  assign offset    = haddr - BASE_ADDR;
  assign range_err = (offset[ADDR_WIDTH-1:MEM_ADDR_BITS] != '0);
  assign size_err  = (hsize > 3'(LB));
  assign align_err = ((haddr & ((ADDR_WIDTH'(1) << hsize) - 1'b1)) != '0);
  assign seq_err   = (htrans == HTRANS_SEQ) && (!seq_ok || haddr != exp_addr || cross_1k);
  assign err       = range_err || size_err || align_err || seq_err;

  ahb_burst_tracker #(.ADDR_WIDTH(ADDR_WIDTH)) u_tracker (
    .hclk     (hclk),
    .hreset   (hreset),
    .load     (accept && htrans == HTRANS_NONSEQ && !err),
    .advance  (accept && htrans == HTRANS_SEQ && !err),
    .clear    (accept && xfer && err),
    .haddr    (haddr),
    .hburst   (hburst),
    .hsize    (hsize),
    .exp_addr (exp_addr),
    .seq_ok   (seq_ok),
    .cross_1k (cross_1k)
  );

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state   <= ST_IDLE;
      off_r   <= '0;
      size_r  <= '0;
      write_r <= 1'b0;
      wcnt    <= '0;
    end else begin
      state <= state_next;
      if (accept && xfer && !err) begin
        off_r   <= offset[MEM_ADDR_BITS-1:0];
        size_r  <= hsize;
        write_r <= hwrite;
        wcnt    <= wait_states;
      end else if (state == ST_DATA && wcnt != '0) begin
        wcnt <= wcnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ERR1: state_next = ST_ERR2;
      ST_DATA: state_next = (wcnt != '0) ? ST_DATA : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (accept && xfer) state_next = err ? ST_ERR1 : ST_DATA;
  end

  assign hreadyout = !((state == ST_ERR1) || (state == ST_DATA && wcnt != '0));
  assign hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  // Lanes assume BASE_ADDR is aligned to the bus width.
  assign word_idx = off_r[MEM_ADDR_BITS-1:LB];

  always_comb begin
    lanes = '0;
    for (int i = 0; i < NB; i++)
      lanes[i] = (i >= int'(off_r[LB-1:0])) &&
                 (i < int'(off_r[LB-1:0]) + (1 << size_r)) && hwstrb[i];
  end

  always_ff @(posedge hclk) begin
    if (state == ST_DATA && wcnt == '0 && write_r)
      for (int i = 0; i < NB; i++)
        if (lanes[i]) mem[{word_idx, LB'(i)}] <= hwdata[8*i +: 8];
  end

  always_comb begin
    hrdata = '0;
    if (state == ST_DATA && wcnt == '0 && !write_r)
      for (int i = 0; i < NB; i++)
        hrdata[8*i +: 8] = mem[{word_idx, LB'(i)}];
  end

endmodule

// File: tb/tb_ahb_memory_subordinate.sv
module tb_ahb_memory_subordinate;
  import ahb_memory_subordinate_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        hselx = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = '0;
  logic [2:0]  hburst = '0;
  logic [2:0]  hsize = '0;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = '0;
  logic [3:0]  hwstrb = '0;
  logic        hready;
  logic [3:0]  wait_states = '0;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  int n_chk = 0;
  int n_bad = 0;

  assign hready = hreadyout;
  always #5 hclk = ~hclk;

  ahb_memory_subordinate dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .hselx       (hselx),
    .haddr       (haddr),
    .htrans      (htrans),
    .hburst      (hburst),
    .hsize       (hsize),
    .hwrite      (hwrite),
    .hwdata      (hwdata),
    .hwstrb      (hwstrb),
    .hready      (hready),
    .wait_states (wait_states),
    .hreadyout   (hreadyout),
    .hresp       (hresp),
    .hrdata      (hrdata)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One non-pipelined transfer: address phase, then IDLE while the data phase runs.
  task automatic xfer(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] b,
                      input logic [2:0] s, input logic w, input logic [31:0] wd,
                      input logic [3:0] st, input logic [3:0] ws,
                      output logic rsp, output logic [31:0] rd, output int waits);
    @(negedge hclk);
    hselx = 1'b1; htrans = tr; haddr = a; hburst = b; hsize = s; hwrite = w;
    wait_states = ws;
    @(posedge hclk);
    @(negedge hclk);
    htrans = HTRANS_IDLE; hwdata = wd; hwstrb = st;
    waits = 0;
    while (!hreadyout && waits < 40) begin
      waits++;
      @(negedge hclk);
    end
    if (waits >= 40) check_val("timeout", 32'(waits), 32'd0);
    rsp = hresp;
    rd  = hrdata;
    @(posedge hclk);
  endtask

  task automatic run(input string tag, input logic [1:0] tr, input logic [31:0] a,
                     input logic [2:0] b, input logic [2:0] s, input logic w,
                     input logic [31:0] d, input logic [3:0] st, input logic [3:0] ws,
                     input logic exp_err, input logic [31:0] exp_rd);
    logic        rsp;
    logic [31:0] rd;
    int          waits;
    xfer(tr, a, b, s, w, d, st, ws, rsp, rd, waits);
    check_val({tag, ".resp"}, 32'(rsp), 32'(exp_err));
    check_val({tag, ".wait"}, 32'(waits), exp_err ? 32'd1 : (tr[1] ? 32'(ws) : 32'd0));
    if (!w && !exp_err) check_val({tag, ".rdata"}, rd, exp_rd);
  endtask

  localparam logic [1:0] NS = HTRANS_NONSEQ;
  localparam logic [1:0] SQ = HTRANS_SEQ;
  localparam logic [2:0] SG = HBURST_SINGLE;
  localparam logic [2:0] WD = HSIZE_WORD;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge hclk);
    #1;
    check_val("rst.hreadyout", 32'(hreadyout), 32'd1);
    check_val("rst.hresp", 32'(hresp), 32'd0);
    check_val("rst.hrdata", hrdata, 32'd0);
    @(negedge hclk);
    hreset = 1'b0;

    // single write/read
    run("t2w", NS, 32'h10, SG, WD, 1'b1, 32'hA5A5_1234, 4'hF, 4'd0, 1'b0, 32'h0);
    run("t2r", NS, 32'h10, SG, WD, 1'b0, 32'h0, 4'hF, 4'd0, 1'b0, 32'hA5A5_1234);

    // reset in the 2nd wait cycle of a 5-wait write
    @(negedge hclk);
    hselx = 1'b1; htrans = NS; haddr = 32'h10; hburst = SG; hsize = WD; hwrite = 1'b1;
    wait_states = 4'd5;
    @(posedge hclk);
    @(negedge hclk);
    htrans = HTRANS_IDLE; hwdata = 32'hDEAD_BEEF; hwstrb = 4'hF;
    check_val("t1.stall", 32'(hreadyout), 32'd0);
    @(negedge hclk);
    hreset = 1'b1;
    #1;
    check_val("t1.hreadyout", 32'(hreadyout), 32'd1);
    check_val("t1.hresp", 32'(hresp), 32'd0);
    check_val("t1.hrdata", hrdata, 32'd0);
    @(posedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
    repeat (6) @(posedge hclk);
    run("t1r", NS, 32'h10, SG, WD, 1'b0, 32'h0, 4'hF, 4'd0, 1'b0, 32'hA5A5_1234);

    // wait states and strobes
    run("t3w0", NS, 32'h20, SG, WD, 1'b1, 32'h1122_3344, 4'hF, 4'd0, 1'b0, 32'h0);
    run("t3hw", NS, 32'h22, SG, HSIZE_HALFWORD, 1'b1, 32'hBEEF_BEEF, 4'hF, 4'd3, 1'b0, 32'h0);
    run("t3r1", NS, 32'h20, SG, WD, 1'b0, 32'h0, 4'hF, 4'd0, 1'b0, 32'hBEEF_3344);
    run("t3st", NS, 32'h20, SG, HSIZE_HALFWORD, 1'b1, 32'h0000_5566, 4'b0001, 4'd1, 1'b0, 32'h0);
    run("t3r2", NS, 32'h20, SG, WD, 1'b0, 32'h0, 4'hF, 4'd2, 1'b0, 32'hBEEF_3366);

    // WRAP4
    run("t4pre", NS, 32'h40, SG, WD, 1'b1, 32'h4040_4040, 4'hF, 4'd0, 1'b0, 32'h0);
    run("t4b0", NS, 32'h38, HBURST_WRAP4, WD, 1'b1, 32'hA0, 4'hF, 4'd0, 1'b0, 32'h0);
    run("t4b1", SQ, 32'h3C, HBURST_WRAP4, WD, 1'b1, 32'hA1, 4'hF, 4'd0, 1'b0, 32'h0);
    run("t4b2", SQ, 32'h30, HBURST_WRAP4, WD, 1'b1, 32'hA2, 4'hF, 4'd1, 1'b0, 32'h0);
    run("t4b3", SQ, 32'h34, HBURST_WRAP4, WD, 1'b1, 32'hA3, 4'hF, 4'd0, 1'b0, 32'h0);
    run("t4r30", NS, 32'h30, SG, WD, 1'b0, 32'h0, 4'hF, 4'd0, 1'b0, 32'hA2);
    run("t4r3c", NS, 32'h3C, SG, WD, 1'b0, 32'h0, 4'hF, 4'd0, 1'b0, 32'hA1);
    run("t4e0", NS, 32'h38, HBURST_WRAP4, WD, 1'b1, 32'hB0, 4'hF, 4'd0, 1'b0, 32'h0);
    run("t4e1", SQ, 32'h3C, HBURST_WRAP4, WD, 1'b1, 32'hB1, 4'hF, 4'd0, 1'b0, 32'h0);
    run("t4e2", SQ, 32'h40, HBURST_WRAP4, WD, 1'b1, 32'hB2, 4'hF, 4'd0, 1'b1, 32'h0);
    run("t4r40", NS, 32'h40, SG, WD, 1'b0, 32'h0, 4'hF, 4'd0, 1'b0, 32'h4040_4040);
    run("t4r38", NS, 32'h38, SG, WD, 1'b0, 32'h0, 4'hF, 4'd0, 1'b0, 32'hB0);

    // range / size / alignment, IDLE and BUSY
    run("t5rng", NS, 32'h1000, SG, WD, 1'b0, 32'h0, 4'hF, 4'd3, 1'b1, 32'h0);
    run("t5rngw", NS, 32'h1000, SG, WD, 1'b1, 32'h5555_5555, 4'hF, 4'd0, 1'b1, 32'h0);
    run("t5algn", NS, 32'h02, SG, WD, 1'b0, 32'h0, 4'hF, 4'd0, 1'b1, 32'h0);
    run("t5size", NS, 32'h08, SG, HSIZE_DWORD, 1'b0, 32'h0, 4'hF, 4'd0, 1'b1, 32'h0);
    run("t5idle", HTRANS_IDLE, 32'h10, SG, WD, 1'b0, 32'h0, 4'hF, 4'd7, 1'b0, 32'h0);
    run("t5busy", HTRANS_BUSY, 32'h10, SG, WD, 1'b0, 32'h0, 4'hF, 4'd7, 1'b0, 32'h0);

    // burst limits
    run("t6k0", NS, 32'h3F8, HBURST_INCR4, WD, 1'b1, 32'hC0, 4'hF, 4'd0, 1'b0, 32'h0);
    run("t6k1", SQ, 32'h3FC, HBURST_INCR4, WD, 1'b1, 32'hC1, 4'hF, 4'd0, 1'b0, 32'h0);
    run("t6k2", SQ, 32'h400, HBURST_INCR4, WD, 1'b1, 32'hC2, 4'hF, 4'd0, 1'b1, 32'h0);
    run("t6pre", NS, 32'h110, SG, WD, 1'b1, 32'h0110_0110, 4'hF, 4'd0, 1'b0, 32'h0);
    run("t6b0", NS, 32'h100, HBURST_INCR4, WD, 1'b1, 32'hD0, 4'hF, 4'd0, 1'b0, 32'h0);
    run("t6b1", SQ, 32'h104, HBURST_INCR4, WD, 1'b1, 32'hD1, 4'hF, 4'd0, 1'b0, 32'h0);
    run("t6b2", SQ, 32'h108, HBURST_INCR4, WD, 1'b1, 32'hD2, 4'hF, 4'd0, 1'b0, 32'h0);
    run("t6b3", SQ, 32'h10C, HBURST_INCR4, WD, 1'b1, 32'hD3, 4'hF, 4'd0, 1'b0, 32'h0);
    run("t6b4", SQ, 32'h110, HBURST_INCR4, WD, 1'b1, 32'hD4, 4'hF, 4'd0, 1'b1, 32'h0);
    run("t6r110", NS, 32'h110, SG, WD, 1'b0, 32'h0, 4'hF, 4'd0, 1'b0, 32'h0110_0110);
    run("t6r10c", NS, 32'h10C, SG, WD, 1'b0, 32'h0, 4'hF, 4'd0, 1'b0, 32'hD3);
    run("t6r3fc", NS, 32'h3FC, SG, WD, 1'b0, 32'h0, 4'hF, 4'd0, 1'b0, 32'hC1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
